sram_arbiter: RTL and testbench

- Shares the single external 16-bit asynchronous SRAM between two requesters: port A (CPU, read/write) and port B (video/scan reader, read-only).
- Owns all SRAM strobes (CSX, OEX, WEX), the address bus and the bidirectional DATA bus.
- Sequences each access through a fixed-timing state machine with programmable wait cycles, arbitrates round-robin and returns read data with a one-cycle acknowledge pulse.
- Sits between the CPU/video logic and the board SRAM pins.

---
 rtl/sram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between a read/write CPU port (A)
// and a read-only video port (B); every SRAM strobe, the address and the data bus are registered.
`timescale 1ns/1ps
module sram_arbiter #(
   parameter int AW       = 18,
   parameter int RD_WAIT  = 2,
   parameter int WR_PULSE = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [15:0]   a_wdata,
   output logic          a_ack,
   output logic [15:0]   a_rdata,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   output logic          b_ack,
   output logic [15:0]   b_rdata,
   output logic [AW-1:0] ADDR,
   inout  wire  [15:0]   DATA,
   output logic          CSX,
   output logic          OEX,
   output logic          WEX
);

   typedef enum logic [2:0] {IDLE, RD, WS, WP, WH} state_t;

   localparam logic [7:0] RD_CNT = 8'(RD_WAIT - 1);
   localparam logic [7:0] WP_CNT = 8'(WR_PULSE - 1);

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          gnt_b_q, gnt_b_d;
   logic          prio_b_q, prio_b_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   dout_q, dout_d;
   logic          dat_oe_q, dat_oe_d;
   logic          csx_q, csx_d;
   logic          oex_q, oex_d;
   logic          wex_q, wex_d;
   logic          a_ack_q, a_ack_d;
   logic          b_ack_q, b_ack_d;
   logic [15:0]   a_rdata_q, a_rdata_d;
   logic [15:0]   b_rdata_q, b_rdata_d;
   logic          grant_b_s;

   // B wins when it is the only requester, or when both ask and A was served last
   assign grant_b_s = b_req & (~a_req | prio_b_q);

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         gnt_b_q   <= 1'b0;
         prio_b_q  <= 1'b0;
         addr_q    <= '0;
         dout_q    <= 16'd0;
         dat_oe_q  <= 1'b0;
         csx_q     <= 1'b1;
         oex_q     <= 1'b1;
         wex_q     <= 1'b1;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= 16'd0;
         b_rdata_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_b_q   <= gnt_b_d;
         prio_b_q  <= prio_b_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         dat_oe_q  <= dat_oe_d;
         csx_q     <= csx_d;
         oex_q     <= oex_d;
         wex_q     <= wex_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   // Next-state and next-output logic; strobes are computed one cycle ahead of the pins
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_b_d   = gnt_b_q;
      prio_b_d  = prio_b_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      dat_oe_d  = dat_oe_q;
      csx_d     = csx_q;
      oex_d     = oex_q;
      wex_d     = wex_q;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      case (state_q)
         IDLE: begin
            csx_d    = 1'b1;
            oex_d    = 1'b1;
            wex_d    = 1'b1;
            dat_oe_d = 1'b0;
            if (a_req | b_req) begin
               gnt_b_d  = grant_b_s;
               prio_b_d = ~grant_b_s;
               csx_d    = 1'b0;
               if (grant_b_s) begin
                  addr_d  = b_addr;
                  oex_d   = 1'b0;
                  cnt_d   = RD_CNT;
                  state_d = RD;
               end else if (a_we) begin
                  addr_d   = a_addr;
                  dout_d   = a_wdata;
                  dat_oe_d = 1'b1;
                  state_d  = WS;
               end else begin
                  addr_d  = a_addr;
                  oex_d   = 1'b0;
                  cnt_d   = RD_CNT;
                  state_d = RD;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD: begin
            if (cnt_q == 8'd0) begin
               if (gnt_b_q) begin
                  b_rdata_d = DATA;
               end else begin
                  a_rdata_d = DATA;
               end
               a_ack_d = ~gnt_b_q;
               b_ack_d = gnt_b_q;
               csx_d   = 1'b1;
               oex_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         WS: begin
            wex_d   = 1'b0;
            cnt_d   = WP_CNT;
            state_d = WP;
         end
         WP: begin
            if (cnt_q == 8'd0) begin
               wex_d   = 1'b1;
               state_d = WH;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         WH: begin
            // Only port A can own a write, so the write ack is always A's
            csx_d    = 1'b1;
            dat_oe_d = 1'b0;
            a_ack_d  = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            csx_d    = 1'b1;
            oex_d    = 1'b1;
            wex_d    = 1'b1;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   assign DATA    = dat_oe_q ? dout_q : 16'bz;
   assign ADDR    = addr_q;
   assign CSX     = csx_q;
   assign OEX     = oex_q;
   assign WEX     = wex_q;
   assign a_ack   = a_ack_q;
   assign b_ack   = b_ack_q;
   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a behavioural SRAM, a scoreboard of expected acks filled by
// the stimulus, and a negedge monitor that checks acks, strobe widths and bus turnaround.
`timescale 1ns/1ps
module tb_sram_arbiter;
   localparam int AW       = 18;
   localparam int RD_WAIT  = 2;
   localparam int WR_PULSE = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          a_req = 1'b0;
   logic          a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [15:0]   a_wdata = 16'd0;
   logic          a_ack;
   logic [15:0]   a_rdata;
   logic          b_req = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic          b_ack;
   logic [15:0]   b_rdata;
   logic [AW-1:0] ADDR;
   wire  [15:0]   DATA;
   logic          CSX, OEX, WEX;

   always #5 clk = ~clk;

   sram_arbiter #(.AW(AW), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata),
      .ADDR(ADDR), .DATA(DATA), .CSX(CSX), .OEX(OEX), .WEX(WEX)
   );

   // Behavioural asynchronous SRAM
   logic [15:0] mem [0:(1<<AW)-1];
   assign DATA = (!CSX && !OEX && WEX) ? mem[ADDR] : 16'bz;
   always @(posedge clk) begin
      if (!CSX && !WEX) mem[ADDR] <= DATA;
   end

   typedef struct {
      logic        is_b;
      logic [15:0] a_rd;
      logic [15:0] b_rd;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   logic [15:0] cur_a = 16'd0;
   logic [15:0] cur_b = 16'd0;
   logic [15:0] exp_wdata = 16'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ack(input logic is_b, input int at);
      exp_t e;
      e.is_b = is_b;
      e.a_rd = cur_a;
      e.b_rd = cur_b;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: acks against the scoreboard, strobe widths, data bus value and turnaround
   int   oex_run = 0;
   int   wex_run = 0;
   logic prev_drv = 1'b0;
   always @(negedge clk) begin
      logic drv;
      drv = dut.dat_oe_q;
      if (!OEX) check("bus_turnaround", {31'd0, drv | prev_drv}, 32'd0);
      if (drv) check("data_bus", {16'd0, DATA}, {16'd0, exp_wdata});
      if (!OEX) oex_run <= oex_run + 1;
      else begin
         if (oex_run != 0) check("oex_width", oex_run, RD_WAIT);
         oex_run <= 0;
      end
      if (!WEX) wex_run <= wex_run + 1;
      else begin
         if (wex_run != 0) check("wex_width", wex_run, WR_PULSE);
         wex_run <= 0;
      end
      prev_drv <= drv;
      if (a_ack || b_ack) begin
         if (a_ack && b_ack) check("dual_ack", 32'd1, 32'd0);
         if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
         else begin
            mon_e = sb.pop_front();
            check("ack_port", {31'd0, b_ack}, {31'd0, mon_e.is_b});
            check("ack_cycle", cyc, mon_e.cyc);
            check("a_rdata", {16'd0, a_rdata}, {16'd0, mon_e.a_rd});
            check("b_rdata", {16'd0, b_rdata}, {16'd0, mon_e.b_rd});
         end
      end
   end

   task automatic run_a(input logic we, input logic [AW-1:0] addr, input logic [15:0] wd,
                        input logic [15:0] rd);
      bit seen;
      @(negedge clk);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      if (we) exp_wdata = wd;
      else cur_a = rd;
      expect_ack(1'b0, cyc + 1 + (we ? WR_PULSE + 2 : RD_WAIT));
      @(negedge clk);
      check("addr_latch", {14'd0, ADDR}, {14'd0, addr});
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (a_ack) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) check("a_ack_timeout", 32'd0, 32'd1);
      a_req = 1'b0; a_we = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      cur_a = 16'd0;
      cur_b = 16'd0;
   endtask

   initial begin
      int n;
      mem[18'h00005] = 16'hBEEF;
      mem[18'h00010] = 16'h1111;
      mem[18'h00020] = 16'h2222;
      mem[18'h00030] = 16'h3333;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_csx", {31'd0, CSX}, 32'd1);
      check("rst_oex", {31'd0, OEX}, 32'd1);
      check("rst_wex", {31'd0, WEX}, 32'd1);
      check("rst_drive", {31'd0, dut.dat_oe_q}, 32'd0);
      check("rst_addr", {14'd0, ADDR}, 32'd0);
      check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
      check("rst_a_rdata", {16'd0, a_rdata}, 32'd0);
      check("rst_b_rdata", {16'd0, b_rdata}, 32'd0);

      // Single read, write to the top address, read back
      run_a(1'b0, 18'h00005, 16'h0000, 16'hBEEF);
      run_a(1'b1, 18'h3FFFF, 16'h1234, 16'h0000);
      @(negedge clk);
      check("sram_mem", {16'd0, mem[18'h3FFFF]}, 32'h1234);
      run_a(1'b0, 18'h3FFFF, 16'h0000, 16'h1234);

      // Both requesters from reset: A,B,A,B,A,B three cycles apart
      do_reset(2);
      @(negedge clk);
      n = cyc;
      a_req = 1'b1; a_we = 1'b0; a_addr = 18'h00010;
      b_req = 1'b1; b_addr = 18'h00020;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) cur_a = 16'h1111;
         else cur_b = 16'h2222;
         expect_ack(k % 2 == 1, n + 3 + 3 * k);
      end
      repeat (18) @(negedge clk);
      a_req = 1'b0; b_req = 1'b0;

      // Continuous B with a single A request: A is served right after the B in flight
      @(negedge clk);
      n = cyc;
      b_req = 1'b1; b_addr = 18'h00020;
      expect_ack(1'b1, n + 3);
      cur_a = 16'h3333;
      expect_ack(1'b0, n + 6);
      expect_ack(1'b1, n + 9);
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 18'h00030;
      repeat (5) @(negedge clk);
      a_req = 1'b0;
      repeat (3) @(negedge clk);
      b_req = 1'b0;

      // Reset during the write pulse: no ack, strobes released next cycle
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00100; a_wdata = 16'h5555;
      exp_wdata = 16'h5555;
      @(negedge clk);
      @(negedge clk);
      check("wp_wex_low", {31'd0, WEX}, 32'd0);
      reset = 1'b1; a_req = 1'b0; a_we = 1'b0;
      @(negedge clk);
      check("abort_wex", {31'd0, WEX}, 32'd1);
      check("abort_csx", {31'd0, CSX}, 32'd1);
      check("abort_oex", {31'd0, OEX}, 32'd1);
      check("abort_drive", {31'd0, dut.dat_oe_q}, 32'd0);
      check("abort_a_rdata", {16'd0, a_rdata}, 32'd0);
      check("abort_b_rdata", {16'd0, b_rdata}, 32'd0);
      reset = 1'b0;
      cur_a = 16'd0; cur_b = 16'd0;
      run_a(1'b0, 18'h3FFFF, 16'h0000, 16'h1234);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drain", sb.size(), 32'd0);
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
